// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit buffer: data width and launch FSM state encoding.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_LAUNCH      = 3'd1;
    localparam logic [2:0] ST_WAIT_ACTIVE = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE   = 3'd3;
    localparam logic [2:0] ST_COOLDOWN    = 3'd4;

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with occupancy count; full/empty come from the count, never from pointer equality.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   push,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   pop,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [ADDR_W:0]        count,
    output logic                   overflow
);

    logic [UART_DATA_W-1:0] mem_q [DEPTH];
    logic [UART_DATA_W-1:0] mem_d [DEPTH];
    logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]        count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   full_s, empty_s, push_ok_s, pop_ok_s;

    // DEPTH is a power of two, so the count MSB alone marks a full FIFO
    assign full_s   = count_q[ADDR_W];
    assign empty_s  = (count_q == {(ADDR_W+1){1'b0}});
    assign full     = full_s;
    assign empty    = empty_s;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign rd_data  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers, count and the overflow pulse
    always_comb begin
        push_ok_s  = push & ~full_s;
        pop_ok_s   = pop & ~empty_s;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = push & full_s;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {UART_DATA_W{1'b0}};
            end
            wr_ptr_q   <= {ADDR_W{1'b0}};
            rd_ptr_q   <= {ADDR_W{1'b0}};
            count_q    <= {(ADDR_W+1){1'b0}};
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers host bytes and launches them one at a time into uart_TX, paced by its Active/Done feedback.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                   i_Clock,
    input  logic                   i_Rst_L,
    input  logic                   i_Wr_DV,
    input  logic [UART_DATA_W-1:0] i_Wr_Byte,
    output logic                   o_Full,
    output logic                   o_Empty,
    output logic [ADDR_W:0]        o_Count,
    output logic                   o_Overflow,
    output logic                   o_Tx_DV,
    output logic [UART_DATA_W-1:0] o_Tx_Byte,
    input  logic                   i_Tx_Active,
    input  logic                   i_Tx_Done
);

    logic [2:0]             state_q, state_d;
    logic                   tx_dv_q, tx_dv_d;
    logic [UART_DATA_W-1:0] tx_byte_q, tx_byte_d;
    logic                   pop_s;
    logic [UART_DATA_W-1:0] rd_data_s;

    uart_byte_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (i_Clock),
        .rst_l    (i_Rst_L),
        .push     (i_Wr_DV),
        .wr_data  (i_Wr_Byte),
        .pop      (pop_s),
        .rd_data  (rd_data_s),
        .full     (o_Full),
        .empty    (o_Empty),
        .count    (o_Count),
        .overflow (o_Overflow)
    );

    assign o_Tx_DV   = tx_dv_q;
    assign o_Tx_Byte = tx_byte_q;

    // Launch sequencer; after reset, IDLE also waits out a frame uart_TX may still be sending
    always_comb begin
        state_d   = state_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        pop_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!o_Empty && !i_Tx_Active) begin
                    pop_s     = 1'b1;
                    tx_byte_d = rd_data_s;
                    tx_dv_d   = 1'b1;
                    state_d   = ST_LAUNCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT_ACTIVE;
            end
            ST_WAIT_ACTIVE: begin
                // Done wins so a frame whose Active was missed can never hang the sequencer
                if (i_Tx_Done) begin
                    state_d = ST_COOLDOWN;
                end else if (i_Tx_Active) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    state_d = ST_WAIT_ACTIVE;
                end
            end
            ST_WAIT_DONE: begin
                if (i_Tx_Done) begin
                    state_d = ST_COOLDOWN;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_COOLDOWN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer and launch output registers with synchronous active-low reset
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_L) begin
            state_q   <= ST_IDLE;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= {UART_DATA_W{1'b0}};
        end else begin
            state_q   <= state_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
        end
    end

endmodule
